// File: rtl/instr_decode_pkg.sv
// Shared constants and types for the IF/ID decode stage: MIPS opcode and
// funct values, ALU operation encodings, FSM states and the control bundle.
package instr_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;

    // jal writes its link address into $ra
    localparam logic [4:0] LINK_REG = 5'd31;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HAZ  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    typedef struct packed {
        logic       jump;
        logic       jump_reg;
        logic       branch;
        logic       inv_zero;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [4:0] dst;
        logic       uses_rt;
        logic       legal;
    } ctrl_t;

    // Control bundle shared by every register-register ALU instruction
    function automatic ctrl_t r_alu(input logic [3:0] op, input logic [4:0] rd);
        ctrl_t c;
        c           = '0;
        c.alu_op    = op;
        c.reg_write = 1'b1;
        c.dst       = rd;
        c.uses_rt   = 1'b1;
        c.legal     = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/instr_decode_stage_decoder.sv
// Pure combinational MIPS-subset decode table: opcode/funct plus the two
// destination candidates in, control bundle out. Unknown encodings give an
// all-zero bundle with legal cleared.
module instr_decoder
    import instr_decode_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output ctrl_t      ctrl
);

    // Table lookup; every path starts from the all-zero bundle
    always_comb begin
        ctrl       = '0;
        ctrl.legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl = r_alu(ALU_ADD, rd);
                    FN_SUB:  ctrl = r_alu(ALU_SUB, rd);
                    FN_AND:  ctrl = r_alu(ALU_AND, rd);
                    FN_OR:   ctrl = r_alu(ALU_OR,  rd);
                    FN_SLT:  ctrl = r_alu(ALU_SLT, rd);
                    FN_JR: begin
                        ctrl.jump_reg = 1'b1;
                        ctrl.dst      = rd;
                    end
                    default: ctrl.legal = 1'b0;
                endcase
            end
            OP_LW: begin
                ctrl.alu_op     = ALU_ADD;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.dst        = rt;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.dst       = rt;
                ctrl.uses_rt   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch   = 1'b1;
                ctrl.inv_zero = (opcode == OP_BNE);
                ctrl.alu_op   = ALU_SUB;
                ctrl.dst      = rt;
                ctrl.uses_rt  = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dst       = LINK_REG;
            end
            OP_ADDI, OP_XORI: begin
                ctrl.alu_op    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dst       = rt;
            end
            default: ctrl.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// IF/ID pipeline stage: IF/ID register, load-use hazard stall with bubble
// insertion, flush on redirect, and control outputs back to fetch.
// Optional macro ILLEGAL_TRAP_EN: an undecodable instruction raises illegal
// and parks the stage in TRAP (stalled, bubbling) until flush or reset.
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int PC_W   = 30,
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_instr,
    input  logic              if_valid,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    output logic              stall,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic              jump,
    output logic              jump_reg,
    output logic              branch,
    output logic              inv_zero,
    output logic [25:0]       target_instr,
    output logic [15:0]       imm16,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] dst,
    output logic [3:0]        alu_op,
    output logic              alu_src,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              illegal
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    state_e          state_q, state_d;

    ctrl_t           ctrl;
    logic            hazard;
    logic            trap_hit;
    logic            present;
    logic            stall_o;
    logic            illegal_o;

    instr_decoder u_decoder (
        .opcode (instr_q[31:26]),
        .funct  (instr_q[5:0]),
        .rt     (instr_q[20:16]),
        .rd     (instr_q[15:11]),
        .ctrl   (ctrl)
    );

    assign rs           = instr_q[25:21];
    assign rt           = instr_q[20:16];
    assign imm16        = instr_q[15:0];
    assign target_instr = instr_q[25:0];
    assign id_pc        = pc_q;

    // Loads into $0 never create a dependency
    assign hazard = valid_q && ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == rs) || ((ex_rt == rt) && ctrl.uses_rt));

`ifdef ILLEGAL_TRAP_EN
    assign trap_hit = valid_q && !ctrl.legal;
`else
    logic legal_unused;
    assign legal_unused = ctrl.legal;
    assign trap_hit     = 1'b0;
`endif

    // Next-state, stall and bubble gating; flush wins over any hold
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        stall_o   = 1'b0;
        present   = valid_q;
        illegal_o = 1'b0;
        case (state_q)
            ST_TRAP: begin
                stall_o = 1'b1;
                present = 1'b0;
            end
            default: begin
                if (trap_hit) begin
                    stall_o   = 1'b1;
                    illegal_o = 1'b1;
                    state_d   = ST_TRAP;
                end else if (hazard) begin
                    stall_o = 1'b1;
                    present = 1'b0;
                    state_d = ST_HAZ;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (!stall_o) begin
            valid_d = if_valid;
            if (if_valid) begin
                pc_d    = if_pc;
                instr_d = if_instr;
            end
        end
    end

    // IF/ID register and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign stall      = stall_o;
    assign id_valid   = present;
    assign illegal    = illegal_o;
    assign jump       = present && ctrl.jump;
    assign jump_reg   = present && ctrl.jump_reg;
    assign branch     = present && ctrl.branch;
    assign inv_zero   = present && ctrl.inv_zero;
    assign alu_src    = present && ctrl.alu_src;
    assign reg_write  = present && ctrl.reg_write;
    assign mem_read   = present && ctrl.mem_read;
    assign mem_write  = present && ctrl.mem_write;
    assign mem_to_reg = present && ctrl.mem_to_reg;
    assign alu_op     = present ? ctrl.alu_op : ALU_NOP;
    assign dst        = present ? ctrl.dst : '0;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage: directed scenarios followed by random
// traffic, all checked against a mnemonic-level reference model.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_instr_decode_stage;
    import instr_decode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [29:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        stall, id_valid;
    logic [29:0] id_pc;
    logic        jump, jump_reg, branch, inv_zero;
    logic [25:0] target_instr;
    logic [15:0] imm16;
    logic [4:0]  rs, rt, dst;
    logic [3:0]  alu_op;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, illegal;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the IF/ID register should hold
    logic        m_valid;
    logic        m_trap;
    logic [29:0] m_pc;
    logic [31:0] m_instr;

    logic [102:0] all_out;
    assign all_out = {stall, id_valid, id_pc, jump, jump_reg, branch, inv_zero,
                      target_instr, imm16, rs, rt, dst, alu_op, alu_src,
                      reg_write, mem_read, mem_write, mem_to_reg, illegal};

    instr_decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_valid     (if_valid),
        .flush        (flush),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .stall        (stall),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .branch       (branch),
        .inv_zero     (inv_zero),
        .target_instr (target_instr),
        .imm16        (imm16),
        .rs           (rs),
        .rt           (rt),
        .dst          (dst),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       jump, jump_reg, branch, inv_zero;
        logic       alu_src, reg_write, mem_read, mem_write, mem_to_reg;
        logic       uses_rt, legal;
        logic [3:0] alu_op;
        logic [4:0] dst;
    } exp_t;

    function automatic string mnemonic(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h20:   return "add";
                6'h22:   return "sub";
                6'h24:   return "and";
                6'h25:   return "or";
                6'h2A:   return "slt";
                6'h08:   return "jr";
                default: return "ill";
            endcase
        end
        case (op)
            6'h23:   return "lw";
            6'h2B:   return "sw";
            6'h04:   return "beq";
            6'h05:   return "bne";
            6'h02:   return "j";
            6'h03:   return "jal";
            6'h08:   return "addi";
            6'h0E:   return "xori";
            default: return "ill";
        endcase
    endfunction

    function automatic exp_t refDecode(input logic [31:0] ins);
        exp_t  e;
        string m;
        e = '0;
        m = mnemonic(ins);
        e.legal = (m != "ill");
        case (m)
            "add":  begin e.reg_write = 1; e.uses_rt = 1; e.dst = ins[15:11]; e.alu_op = ALU_ADD; end
            "sub":  begin e.reg_write = 1; e.uses_rt = 1; e.dst = ins[15:11]; e.alu_op = ALU_SUB; end
            "and":  begin e.reg_write = 1; e.uses_rt = 1; e.dst = ins[15:11]; e.alu_op = ALU_AND; end
            "or":   begin e.reg_write = 1; e.uses_rt = 1; e.dst = ins[15:11]; e.alu_op = ALU_OR;  end
            "slt":  begin e.reg_write = 1; e.uses_rt = 1; e.dst = ins[15:11]; e.alu_op = ALU_SLT; end
            "jr":   begin e.jump_reg = 1; e.dst = ins[15:11]; end
            "lw":   begin e.alu_op = ALU_ADD; e.alu_src = 1; e.reg_write = 1; e.mem_read = 1;
                          e.mem_to_reg = 1; e.dst = ins[20:16]; end
            "sw":   begin e.alu_op = ALU_ADD; e.alu_src = 1; e.mem_write = 1; e.uses_rt = 1;
                          e.dst = ins[20:16]; end
            "beq":  begin e.branch = 1; e.alu_op = ALU_SUB; e.uses_rt = 1; e.dst = ins[20:16]; end
            "bne":  begin e.branch = 1; e.inv_zero = 1; e.alu_op = ALU_SUB; e.uses_rt = 1;
                          e.dst = ins[20:16]; end
            "j":    begin e.jump = 1; end
            "jal":  begin e.jump = 1; e.reg_write = 1; e.dst = 5'd31; end
            "addi": begin e.alu_op = ALU_ADD; e.alu_src = 1; e.reg_write = 1; e.dst = ins[20:16]; end
            "xori": begin e.alu_op = ALU_XOR; e.alu_src = 1; e.reg_write = 1; e.dst = ins[20:16]; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkAllZero(input string tag);
        n_vec++;
        assert (all_out === '0) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=0", tag, all_out);
        end
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_trap  = 1'b0;
        m_pc    = '0;
        m_instr = '0;
    endtask

    task automatic applyStimulus(input logic [29:0] pc, input logic [31:0] ins, input logic v,
                                 input logic fl, input logic mr, input logic [4:0] ert);
        if_pc       = pc;
        if_instr    = ins;
        if_valid    = v;
        flush       = fl;
        ex_mem_read = mr;
        ex_rt       = ert;
        #2;
    endtask

    // Compare every output against the model, then clock and advance the model
    task automatic checkOutput();
        exp_t e;
        logic haz, ill_now, shown, x_stall;
        e   = refDecode(m_instr);
        haz = m_valid && ex_mem_read && (ex_rt != 5'd0) &&
              ((ex_rt == m_instr[25:21]) || ((ex_rt == m_instr[20:16]) && e.uses_rt));
`ifdef ILLEGAL_TRAP_EN
        ill_now = m_valid && !m_trap && !e.legal;
`else
        ill_now = 1'b0;
`endif
        x_stall = m_trap || ill_now || haz;
        shown   = m_valid && !m_trap && (ill_now || !haz);
        chk("stall",      32'(stall),        32'(x_stall));
        chk("id_valid",   32'(id_valid),     32'(shown));
        chk("illegal",    32'(illegal),      32'(ill_now));
        chk("id_pc",      32'(id_pc),        32'(m_pc));
        chk("target",     32'(target_instr), 32'(m_instr[25:0]));
        chk("imm16",      32'(imm16),        32'(m_instr[15:0]));
        chk("rs",         32'(rs),           32'(m_instr[25:21]));
        chk("rt",         32'(rt),           32'(m_instr[20:16]));
        chk("dst",        32'(dst),          shown ? 32'(e.dst) : 32'd0);
        chk("alu_op",     32'(alu_op),       shown ? 32'(e.alu_op) : 32'd0);
        chk("redirect",   32'({jump, jump_reg, branch, inv_zero}),
            shown ? 32'({e.jump, e.jump_reg, e.branch, e.inv_zero}) : 32'd0);
        chk("datapath",   32'({alu_src, reg_write, mem_read, mem_write, mem_to_reg}),
            shown ? 32'({e.alu_src, e.reg_write, e.mem_read, e.mem_write, e.mem_to_reg}) : 32'd0);
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_trap  = 1'b0;
        end else if (ill_now) begin
            m_trap = 1'b1;
        end else if (!x_stall) begin
            m_valid = if_valid;
            if (if_valid) begin
                m_pc    = if_pc;
                m_instr = if_instr;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] randInstr();
        logic [5:0] fns [6];
        logic [5:0] ops [8];
        int         k;
        logic [4:0] r_s, r_t, r_d;
        logic [15:0] imm;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0E};
        k   = int'($urandom_range(0, 15));
        r_s = 5'($urandom_range(0, 3));
        r_t = 5'($urandom_range(0, 3));
        r_d = 5'($urandom_range(0, 31));
        imm = 16'($urandom_range(0, 65535));
        if (k < 6)       return {6'h00, r_s, r_t, r_d, 5'd0, fns[k]};
        else if (k < 14) return {ops[k-6], r_s, r_t, imm};
        else             return $urandom;
    endfunction

    initial begin
        rst_n = 1'b0;
        modelReset();
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, 5'd0);
        chkAllZero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // beq $4,$5,3
        applyStimulus(30'h4, 32'h10850003, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h5, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("beq_branch", 32'({branch, inv_zero, reg_write}), 32'b100);
        chk("beq_rs_rt",  32'({rs, rt}), 32'({5'd4, 5'd5}));
        chk("beq_imm",    32'(imm16), 32'h3);
        checkOutput();

        // jal 9 from PC 0x10
        applyStimulus(30'h10, 32'h0C000009, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h11, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("jal_ctrl",   32'({jump, reg_write}), 32'b11);
        chk("jal_target", 32'(target_instr), 32'd9);
        chk("jal_dst",    32'(dst), 32'd31);
        chk("jal_pc",     32'(id_pc), 32'h10);
        checkOutput();

        // load-use: add $10,$8,$8 behind lw $8
        applyStimulus(30'h20, 32'h01085020, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h21, 32'h00001820, 1'b1, 1'b0, 1'b1, 5'd8);
        chk("lu_stall",   32'({stall, id_valid}), 32'b10);
        checkOutput();
        applyStimulus(30'h21, 32'h00001820, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("lu_replay",  32'({stall, id_valid, dst}), 32'({1'b0, 1'b1, 5'd10}));
        chk("lu_pc",      32'(id_pc), 32'h20);
        checkOutput();
        applyStimulus(30'h22, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0);
        chk("lu_r0",      32'({stall, id_valid}), 32'b01);
        checkOutput();

        // flush in the same cycle as a hazard
        applyStimulus(30'h30, 32'h01085020, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h31, 32'h01085020, 1'b1, 1'b1, 1'b1, 5'd8);
        checkOutput();
        applyStimulus(30'h32, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8);
        chk("flush_haz",  32'({stall, id_valid}), 32'b00);
        checkOutput();

        // async reset while parked in HAZ
        applyStimulus(30'h40, 32'h01085020, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h41, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8);
        checkOutput();
        applyStimulus(30'h41, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b0;
        #1;
        chkAllZero("async_reset");
        modelReset();
        #1;
        rst_n = 1'b1;
        applyStimulus(30'h50, 32'h2128FFFF, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h51, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("post_reset", 32'({id_valid, alu_src, reg_write, dst}), 32'({3'b111, 5'd8}));
        checkOutput();

        // opcode 0x3F
        applyStimulus(30'h60, 32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h61, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_raise",  32'({illegal, stall, reg_write}), 32'b110);
        checkOutput();
        applyStimulus(30'h61, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0);
        chk("ill_trap",   32'({illegal, stall, id_valid}), 32'b010);
        checkOutput();
        applyStimulus(30'h61, 32'h0, 1'b1, 1'b1, 1'b0, 5'd0);
        checkOutput();
        applyStimulus(30'h62, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("ill_freed",  32'({stall, id_valid}), 32'b00);
`else
        chk("ill_nop",    32'({illegal, stall, id_valid, reg_write, jump, alu_op}),
            32'({4'b0010, 1'b0, 4'd0}));
`endif
        checkOutput();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(30'($urandom), randInstr(),
                          $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 9) < 4,
                          5'($urandom_range(0, 3)));
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
